// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer, address and count widths.
// Reused by every FIFO in the tree so widths stay consistent.
package fifo_pkg;

    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // One extra bit keeps full and empty distinguishable.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned depth);
        return (depth != 0) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Simple dual-port storage with registered read, no reset.
// The read register holds its value while re is low.
module stream_fifo_ram #(
    parameter int DW = 24,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO: RAM plus two-entry output
// pipeline (RAM read register, then output register).
module stream_fifo
    import fifo_pkg::*;
#(
    parameter int DW         = 24,
    parameter int DEPTH      = 16,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     s_valid,
    input  logic [DW-1:0]            s_data,
    output logic                     s_ready,
    output logic                     m_valid,
    output logic [DW-1:0]            m_data,
    input  logic                     m_ready,
    output logic [cnt_w(DEPTH)-1:0]  o_count,
    output logic                     o_afull,
    output logic                     o_aempty,
    output logic                     o_ovf
);

    localparam int AW = addr_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          rdy_en;
    logic          s1_valid;
    logic          s2_valid;
    logic [DW-1:0] s2_data;
    logic [DW-1:0] ram_q;
    logic          wr_en;
    logic          rd_en;
    logic          s1_adv;
    logic          ram_re;

    // rdy_en keeps s_ready low until the first edge after reset.
    assign s_ready  = rdy_en & (o_count < FULL_C);
    assign wr_en    = s_valid & s_ready;
    assign rd_en    = s2_valid & m_ready;
    assign s1_adv   = s1_valid & (~s2_valid | m_ready);
    assign ram_re   = (rd_ptr != wr_ptr) & (~s1_valid | s1_adv);
    assign m_valid  = s2_valid;
    assign m_data   = s2_data;
    assign o_afull  = (o_count >= AFULL_C);
    assign o_aempty = (o_count <= AEMPTY_C);

    stream_fifo_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en & ~i_flush),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (s_data),
        .re    (ram_re),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rdy_en   <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            o_count  <= '0;
            o_ovf    <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (i_flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
                o_count  <= '0;
                o_ovf    <= 1'b0;
            end else begin
                if (wr_en)
                    wr_ptr <= wr_ptr + PTR_ONE;
                if (ram_re)
                    rd_ptr <= rd_ptr + PTR_ONE;
                if (ram_re)
                    s1_valid <= 1'b1;
                else if (s1_adv)
                    s1_valid <= 1'b0;
                if (s1_adv) begin
                    s2_valid <= 1'b1;
                    s2_data  <= ram_q;
                end else if (rd_en) begin
                    s2_valid <= 1'b0;
                end
                unique case ({wr_en, rd_en})
                    2'b10:   o_count <= o_count + CNT_ONE;
                    2'b01:   o_count <= o_count - CNT_ONE;
                    default: o_count <= o_count;
                endcase
                if (s_valid & ~s_ready)
                    o_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo with a reference queue of
// accepted words compared against every read transfer.
module tb_stream_fifo;

    localparam int DW = 24;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          i_flush;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [4:0]    o_count;
    logic          o_afull;
    logic          o_aempty;
    logic          o_ovf;

    int n_chk = 0;
    int n_pass = 0;
    logic [DW-1:0] sb [$];

    stream_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (i_flush),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .o_count  (o_count),
        .o_afull  (o_afull),
        .o_aempty (o_aempty),
        .o_ovf    (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    endtask

    // Transfers are judged mid-cycle, then one clock edge passes.
    task automatic step();
        logic [DW-1:0] e;
        @(negedge clk);
        if (i_flush) begin
            sb.delete();
        end else begin
            if (m_valid && m_ready) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_data", 32'(m_data), 32'(e));
                end
            end
            if (s_valid && s_ready)
                sb.push_back(s_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 40 && o_count != 0; i++)
            step();
        step();
        m_ready = 1'b0;
        chk("drain_count", 32'(o_count), 0);
        chk("drain_sb_empty", 32'(sb.size()), 0);
    endtask

    initial begin
        rst = 1'b1;
        i_flush = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(o_count), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_afull", 32'(o_afull), 0);
        chk("rst_aempty", 32'(o_aempty), 1);
        chk("rst_ovf", 32'(o_ovf), 0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(s_ready), 1);

        // two-cycle fall-through
        s_valid = 1'b1;
        s_data = 24'hABCDEF;
        step();
        s_valid = 1'b0;
        chk("ft_n0_valid", 32'(m_valid), 0);
        step();
        chk("ft_n1_valid", 32'(m_valid), 0);
        step();
        chk("ft_n2_valid", 32'(m_valid), 1);
        chk("ft_n2_data", 32'(m_data), 32'h00ABCDEF);
        chk("ft_count", 32'(o_count), 1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("ft_empty_count", 32'(o_count), 0);
        chk("ft_empty_valid", 32'(m_valid), 0);

        // fill to full
        for (int i = 0; i < DEPTH; i++) begin
            s_valid = 1'b1;
            s_data = DW'(i);
            step();
            chk("fill_count", 32'(o_count), 32'(i + 1));
            chk("fill_ready", 32'(s_ready), 32'(i + 1 < DEPTH));
            chk("fill_afull", 32'(o_afull), 32'(i + 1 >= 14));
        end
        s_data = 24'h000099;
        step();
        s_valid = 1'b0;
        chk("ovf_set", 32'(o_ovf), 1);
        chk("ovf_count", 32'(o_count), 16);
        step();
        chk("hold_valid", 32'(m_valid), 1);
        chk("hold_data", 32'(m_data), 0);

        // drain one per cycle
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_valid", 32'(m_valid), 1);
            chk("drain_head", 32'(m_data), 32'(i));
            step();
        end
        m_ready = 1'b0;
        chk("drained_count", 32'(o_count), 0);
        chk("drained_valid", 32'(m_valid), 0);
        chk("drained_aempty", 32'(o_aempty), 1);
        chk("ovf_sticky", 32'(o_ovf), 1);
        chk("drained_sb", 32'(sb.size()), 0);

        // refill and flush
        for (int i = 0; i < DEPTH + 1; i++) begin
            s_valid = 1'b1;
            s_data = DW'($urandom);
            step();
        end
        s_valid = 1'b1;
        i_flush = 1'b1;
        m_ready = 1'b1;
        step();
        i_flush = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("flush_count", 32'(o_count), 0);
        chk("flush_ovf", 32'(o_ovf), 0);
        chk("flush_valid", 32'(m_valid), 0);
        chk("flush_ready", 32'(s_ready), 1);

        // steady state at count 8
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data = DW'($urandom);
            step();
        end
        chk("tp_start_count", 32'(o_count), 8);
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_data = DW'($urandom);
            step();
            chk("tp_count", 32'(o_count), 8);
        end
        s_valid = 1'b0;
        drain();

        // async reset mid-burst
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data = DW'($urandom_range(1, 24'hFFFFFF));
            step();
        end
        chk("mid_count", 32'(o_count), 5);
        s_data = 24'h123456;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(o_count), 0);
        chk("arst_ready", 32'(s_ready), 0);
        chk("arst_valid", 32'(m_valid), 0);
        chk("arst_data", 32'(m_data), 0);
        chk("arst_afull", 32'(o_afull), 0);
        chk("arst_aempty", 32'(o_aempty), 1);
        chk("arst_ovf", 32'(o_ovf), 0);
        sb.delete();
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("arst_ready_up", 32'(s_ready), 1);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data = DW'(24'h500 + i);
            step();
        end
        s_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
